// File: rtl/regfile_host_port.sv
// Host-side master driving the mini register file pins from a valid/ready command channel.
// Define REGFILE_HOST_VERIFY_EN to read back every write and flag mismatches on resp_err.
module regfile_host_port #(
  parameter int ADDR_W   = 3,
  parameter int DATA_W   = 8,
  parameter int READ_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic              resp_write,
  output logic [DATA_W-1:0] resp_data,
  output logic              resp_err,
  output logic [7:0]        pin_ui,
  output logic [7:0]        pin_uio,
  input  logic [7:0]        pin_uo
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_RESP
`ifdef REGFILE_HOST_VERIFY_EN
    , S_VERIFY
`endif
  } state_t;

  state_t            r_state;
  state_t            w_nextState;
  logic              r_started;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [1:0]        r_cnt;
  logic              r_respWrite;
  logic [DATA_W-1:0] r_respData;
  logic              w_accept;
  logic [2:0]        w_addrField;

  assign w_addrField = 3'(r_addr);
  assign w_accept    = req_valid && req_ready;
  assign req_ready   = r_started && (r_state == S_IDLE);
  assign resp_valid  = (r_state == S_RESP);
  assign resp_write  = r_respWrite;
  assign resp_data   = r_respData;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Pins are decoded straight from state so a reset clears them without waiting for an edge.
  always_comb begin
    w_nextState = r_state;
    pin_ui      = 8'h00;
    pin_uio     = 8'h00;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_nextState = req_write ? S_WRITE : S_READ;
        end
      end
      S_WRITE: begin
        pin_ui  = {1'b1, w_addrField, 3'b000, 1'b0};
        pin_uio = 8'(r_wdata);
`ifdef REGFILE_HOST_VERIFY_EN
        w_nextState = S_VERIFY;
`else
        w_nextState = S_RESP;
`endif
      end
      S_READ: begin
        pin_ui = {1'b0, 3'b000, w_addrField, 1'b0};
        if (r_cnt == 2'd0) begin
          w_nextState = S_RESP;
        end
      end
`ifdef REGFILE_HOST_VERIFY_EN
      S_VERIFY: begin
        pin_ui = {1'b0, 3'b000, w_addrField, 1'b0};
        if (r_cnt == 2'd0) begin
          w_nextState = S_RESP;
        end
      end
`endif
      S_RESP: begin
        if (resp_ready) begin
          w_nextState = S_IDLE;
        end
      end
      default: begin
        w_nextState = S_IDLE;
      end
    endcase
  end

`ifdef REGFILE_HOST_VERIFY_EN
  logic r_respErr;
  assign resp_err = r_respErr;
`else
  assign resp_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_started   <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_cnt       <= 2'd0;
      r_respWrite <= 1'b0;
      r_respData  <= '0;
`ifdef REGFILE_HOST_VERIFY_EN
      r_respErr   <= 1'b0;
`endif
    end else begin
      r_started <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            r_cnt   <= 2'(READ_LAT);
          end
        end
        S_WRITE: begin
`ifdef REGFILE_HOST_VERIFY_EN
          r_cnt <= 2'(READ_LAT);
`else
          r_respWrite <= 1'b1;
          r_respData  <= r_wdata;
`endif
        end
        S_READ: begin
          if (r_cnt == 2'd0) begin
            r_respWrite <= 1'b0;
            r_respData  <= DATA_W'(pin_uo);
`ifdef REGFILE_HOST_VERIFY_EN
            r_respErr   <= 1'b0;
`endif
          end else begin
            r_cnt <= r_cnt - 2'd1;
          end
        end
`ifdef REGFILE_HOST_VERIFY_EN
        S_VERIFY: begin
          if (r_cnt == 2'd0) begin
            r_respWrite <= 1'b1;
            r_respData  <= DATA_W'(pin_uo);
            r_respErr   <= (DATA_W'(pin_uo) != r_wdata);
          end else begin
            r_cnt <= r_cnt - 2'd1;
          end
        end
`endif
        default: begin
        end
      endcase
    end
  end

endmodule

// File: doc/regfile_host_port.md
Name: regfile_host_port

Overview:
- Host-side master for the mini register file's pin interface.
- Accepts read/write commands over a valid/ready request channel and drives the register file's dedicated inputs (ui_in) and bidirectional inputs (uio_in).
- Samples the register file's output (uo_out) and returns read data over a valid/ready response channel.
- Sits between an on-chip test sequencer and the tt_um_register pins; serves as the stimulus/readback engine in self-test and in bench.

Parameters:
- ADDR_W, 3, register address width; fixed by pin map.
- DATA_W, 8, register data width; fixed by pin map.
- READ_LAT, 1, number of cycles from the target edge that samples the address to the edge where uo_out holds valid data; legal range 0..3.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  command valid
- req_ready  out  1  command accepted when high together with req_valid
- req_write  in  1  1 = write, 0 = read
- req_addr  in  ADDR_W  register address
- req_wdata  in  DATA_W  write data
- resp_valid  out  1  response valid
- resp_ready  in  1  response consumed when high together with resp_valid
- resp_write  out  1  response belongs to a write
- resp_data  out  DATA_W  read data; echoes wdata for writes
- resp_err  out  1  readback mismatch flag (see Optional Feature)
- pin_ui  out  8  to target ui_in: [7]=we, [6:4]=waddr, [3:1]=raddr, [0]=0
- pin_uio  out  8  to target uio_in: write data
- pin_uo  in  8  from target uo_out: read data

Behaviour:
- Reset (async, rst_n low): state IDLE; pin_ui=0x00, pin_uio=0x00, req_ready=0, resp_valid=0, resp_write=0, resp_data=0x00, resp_err=0, latency counter=0. req_ready rises on the first edge after rst_n deasserts.
- States: IDLE, WRITE, READ, RESP (plus VERIFY when the optional feature is enabled).
- IDLE: req_ready=1; pin_ui=0x00. An accept on edge N latches the command and makes req_ready=0.
- WRITE (cycle after accept):
  - pin_ui={1,addr,3'b000,0}; pin_uio=wdata, held for exactly one cycle; target writes at edge N+1.
  - Then RESP: pin_ui=0x00, resp_write=1, resp_data=wdata. resp_valid is high after edge N+1.
- READ:
  - pin_ui={0,3'b000,addr,0}; pin_uio=0x00, held stable.
  - Counter loads READ_LAT at accept and decrements per edge. When the counter is 0, pin_uo is sampled into resp_data and the state moves to RESP.
  - resp_valid is high after edge N+1+READ_LAT.
- RESP: resp_valid, resp_write, resp_data and resp_err are held stable until resp_ready=1 at an edge, then return to IDLE. req_ready stays 0 throughout RESP, so there is one outstanding command maximum.
- Throughput: minimum of one IDLE cycle between commands. A write occupies 3 edges with resp_ready held high.
- req_valid while not in IDLE: ignored; the requester must hold it.
- Address bits above ADDR_W are not used; fields are zero-padded into pin_ui.
- Reset mid-operation: the in-flight command is dropped and no response is issued. Pins return to 0x00 immediately (asynchronously).
- pin_ui[7] (we) is never high for more than one consecutive cycle.

Optional Feature:
- Macro REGFILE_HOST_VERIFY_EN.
- Defined:
  - After WRITE, the state moves to VERIFY instead of RESP. VERIFY performs a read of the same address using the READ rules above.
  - In RESP, resp_data holds the read-back value and resp_err=1 if it differs from wdata.
  - Write response latency becomes 2+READ_LAT edges after accept.
- Undefined: the VERIFY state is absent and resp_err is tied to 0.

Test Plan:
- Reset: assert rst_n=0 mid-cycle -> all outputs 0x00/0 immediately; req_ready=1 one edge after release.
- Write addr 5 data 0xA7, resp_ready=1 -> pin_ui=0xD0, pin_uio=0xA7 for exactly one cycle. resp_valid one edge later with resp_write=1, resp_data=0xA7.
- Read addr 5 after that write, READ_LAT=1 -> pin_ui=0x0A held 2 cycles. resp_data=0xA7, resp_valid 2 edges after accept.
- Backpressure: read completes with resp_ready=0 for 4 cycles -> resp_valid/resp_data stable, req_ready=0. A second req_valid is ignored until the handshake completes.
- Reset during READ (counter mid-count) -> no resp_valid afterwards; the next command behaves normally.
- With REGFILE_HOST_VERIFY_EN and the target stubbed to return 0x00: write 0x3C -> resp_err=1, resp_data=0x00. With a correct target: resp_err=0, resp_data=0x3C.
